// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, DMA and BRAM port-A signals seen by the dmem port arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-RAM side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  cpu_req;
  logic [3:0]            cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [31:0]           cpu_wdata;
  logic                  cpu_stall;
  logic [31:0]           cpu_rdata;

  logic                  dma_req_valid;
  logic                  dma_req_ready;
  logic [3:0]            dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [31:0]           dma_wdata;
  logic                  dma_resp_valid;
  logic [31:0]           dma_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_we;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  dma_req_valid, dma_we, dma_addr, dma_wdata,
    output dma_req_ready, dma_resp_valid, dma_rdata,
    output mem_addr, mem_we, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output dma_req_valid, dma_we, dma_addr, dma_wdata,
    input  dma_req_ready, dma_resp_valid, dma_rdata,
    input  mem_addr, mem_we, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Fixed-priority CPU/DMA arbiter for the single dmem BRAM port, with a
// starvation counter that forces a DMA grant and 1-cycle read-data return.
//
// last_owner | meaning
// CPU_IDLE   | reset state, no read outstanding
// CPU_RD     | CPU read granted last cycle, mem_dout belongs to CPU
// DMA_RD     | DMA read granted last cycle, mem_dout belongs to DMA
// NONE       | last cycle was a write or had no grant
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_RD   = 2'd1,
    DMA_RD   = 2'd2,
    NONE     = 2'd3
  } owner_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  owner_t                last_owner;
  owner_t                last_owner_nxt;
  logic [7:0]            starve_cnt;
  logic                  grant_dma;
  logic                  grant_cpu;
  logic                  cpu_rd_ret;
  logic                  dma_rd_ret;
  logic [31:0]           cpu_rdata_hold;
  logic [31:0]           dma_rdata_hold;
  logic [ADDR_WIDTH-1:0] addr_sel;

  assign grant_dma = bus.dma_req_valid & (~bus.cpu_req | (starve_cnt == STARVE_MAX)) & ~rst;
  assign grant_cpu = bus.cpu_req & ~grant_dma & ~rst;

  assign bus.dma_req_ready = grant_dma;
  assign bus.cpu_stall     = bus.cpu_req & grant_dma;

  assign addr_sel     = grant_dma ? bus.dma_addr : bus.cpu_addr;
  assign bus.mem_addr = addr_sel;
  assign bus.mem_din  = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.mem_we   = grant_dma ? bus.dma_we : (grant_cpu ? bus.cpu_we : 4'h0);

  always_ff @(posedge clk) begin
    if (rst || grant_dma || !bus.dma_req_valid) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= CPU_IDLE;
    end else begin
      last_owner <= last_owner_nxt;
    end
  end

  always_comb begin
    last_owner_nxt = NONE;
    if (grant_dma && bus.dma_we == 4'h0) begin
      last_owner_nxt = DMA_RD;
    end else if (grant_cpu && bus.cpu_we == 4'h0) begin
      last_owner_nxt = CPU_RD;
    end
  end

  // A return still in flight when reset arrives is suppressed, not delivered.
  assign cpu_rd_ret = (last_owner == CPU_RD) & ~rst;
  assign dma_rd_ret = (last_owner == DMA_RD) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_hold <= 32'd0;
      dma_rdata_hold <= 32'd0;
    end else begin
      if (cpu_rd_ret) cpu_rdata_hold <= bus.mem_dout;
      if (dma_rd_ret) dma_rdata_hold <= bus.mem_dout;
    end
  end

  // Holding the CPU copy keeps a stalled writeback intact across a DMA access.
  assign bus.cpu_rdata      = cpu_rd_ret ? bus.mem_dout : cpu_rdata_hold;
  assign bus.dma_rdata      = dma_rd_ret ? bus.mem_dout : dma_rdata_hold;
  assign bus.dma_resp_valid = dma_rd_ret;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic checked
// against a wait-count / shadow-memory model of the arbitration rules.
module tb_dmem_port_arbiter;
  localparam int AW    = 14;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Read-first BRAM, cleared by reset so that contents are always known
  logic [31:0] bram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) bram[i] <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) bram[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_din[8*b +: 8];
    end
    bus.mem_dout <= bram[bus.mem_addr[5:0]];
  end

  int          checks = 0;
  int          errors = 0;
  int          waited = 0;
  bit          exp_resp = 1'b0;
  logic [31:0] exp_dma_data = 32'd0;
  logic [31:0] exp_cpu_data = 32'd0;
  logic [31:0] refmem [64];
  bit          last_g_dma = 1'b0;
  bit          obs_ready;
  logic [31:0] obs_cpu_rdata;
  logic [31:0] obs_dma_rdata;
  bit          obs_resp;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit cr, input logic [3:0] cwe, input int ca,
                      input logic [31:0] cwd, input bit dv, input logic [3:0] dwe,
                      input int da, input logic [31:0] dwd);
    bit g_dma, g_cpu;
    rst               = r;
    bus.cpu_req       = cr;
    bus.cpu_we        = cwe;
    bus.cpu_addr      = AW'(ca);
    bus.cpu_wdata     = cwd;
    bus.dma_req_valid = dv;
    bus.dma_we        = dwe;
    bus.dma_addr      = AW'(da);
    bus.dma_wdata     = dwd;
    #3;
    g_dma = !r && dv && (!cr || waited == LIMIT);
    g_cpu = !r && cr && !g_dma;
    obs_ready     = bus.dma_req_ready;
    obs_cpu_rdata = bus.cpu_rdata;
    obs_dma_rdata = bus.dma_rdata;
    obs_resp      = bus.dma_resp_valid;
    check("dma_req_ready", 32'(bus.dma_req_ready), 32'(g_dma));
    check("cpu_stall", 32'(bus.cpu_stall), 32'(cr && g_dma));
    check("mem_we", 32'(bus.mem_we), 32'(g_dma ? dwe : (g_cpu ? cwe : 4'h0)));
    check("mem_addr", 32'(bus.mem_addr), 32'(g_dma ? da : ca));
    check("mem_din", bus.mem_din, g_dma ? dwd : cwd);
    check("dma_resp_valid", 32'(bus.dma_resp_valid), 32'(r ? 1'b0 : exp_resp));
    if (!r) begin
      check("dma_rdata", bus.dma_rdata, exp_dma_data);
      check("cpu_rdata", bus.cpu_rdata, exp_cpu_data);
    end
    if (r) begin
      waited       = 0;
      exp_resp     = 1'b0;
      exp_dma_data = 32'd0;
      exp_cpu_data = 32'd0;
      for (int i = 0; i < 64; i++) refmem[i] = 32'd0;
    end else begin
      exp_resp = g_dma && (dwe == 4'h0);
      if (exp_resp) exp_dma_data = refmem[da];
      if (g_cpu && cwe == 4'h0) exp_cpu_data = refmem[ca];
      if (g_dma) refmem[da] = merge(refmem[da], dwd, dwe);
      else if (g_cpu) refmem[ca] = merge(refmem[ca], cwd, cwe);
      if (g_dma || !dv) waited = 0;
      else if (waited < LIMIT) waited = waited + 1;
    end
    last_g_dma = g_dma;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          grant_at;
    bit          dv;
    logic [3:0]  dwe;
    int          da;
    logic [31:0] dwd;

    for (int i = 0; i < 64; i++) refmem[i] = 32'd0;

    // reset
    step(1, 0, 4'h0, 0, 32'd0, 0, 4'h0, 0, 32'd0);
    step(1, 1, 4'hF, 3, 32'h1111, 1, 4'hF, 4, 32'h2222);
    step(0, 0, 4'h0, 0, 32'd0, 0, 4'h0, 0, 32'd0);
    check("reset_cpu_rdata", obs_cpu_rdata, 32'd0);
    check("reset_dma_rdata", obs_dma_rdata, 32'd0);

    // preload through the DMA path with the CPU idle
    step(0, 0, 4'h0, 0, 32'd0, 1, 4'hF, 16, 32'hDEADBEEF);
    step(0, 0, 4'h0, 0, 32'd0, 1, 4'hF, 5, 32'h00001234);
    for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 0, 32'd0, 1, 4'hF, i, 32'hA0A0_0000 + 32'(i));
    step(0, 0, 4'h0, 0, 32'd0, 0, 4'h0, 0, 32'd0);

    // idle DMA read of 0x10
    step(0, 0, 4'h0, 0, 32'd0, 1, 4'h0, 16, 32'd0);
    check("idle_read_ready", 32'(obs_ready), 32'd1);
    step(0, 0, 4'h0, 0, 32'd0, 0, 4'h0, 0, 32'd0);
    check("idle_read_resp", 32'(obs_resp), 32'd1);
    check("idle_read_data", obs_dma_rdata, 32'hDEADBEEF);

    // CPU store stream against a pending DMA write: forced grant on cycle 9
    grant_at = 0;
    for (int k = 1; k <= 12 && grant_at == 0; k++) begin
      step(0, 1, 4'hF, 20 + k, 32'(k), 1, 4'h3, 30, 32'h55AA55AA);
      if (obs_ready) grant_at = k;
    end
    check("contention_grant_cycle", 32'(grant_at), 32'd9);
    step(0, 1, 4'hF, 40, 32'h77, 0, 4'h0, 0, 32'd0);

    // CPU read of addr 5 immediately before a forced DMA read
    for (int k = 1; k <= 7; k++) step(0, 1, 4'h0, 0, 32'd0, 1, 4'h0, 16, 32'd0);
    step(0, 1, 4'h0, 5, 32'd0, 1, 4'h0, 16, 32'd0);
    step(0, 1, 4'h0, 1, 32'd0, 1, 4'h0, 16, 32'd0);
    check("forced_ready", 32'(obs_ready), 32'd1);
    check("stall_cpu_rdata", obs_cpu_rdata, 32'h00001234);
    step(0, 1, 4'h0, 1, 32'd0, 0, 4'h0, 0, 32'd0);
    check("forced_dma_data", obs_dma_rdata, 32'hDEADBEEF);
    check("forced_cpu_rdata_held", obs_cpu_rdata, 32'h00001234);

    // back-to-back DMA reads of 0..3
    for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 0, 32'd0, 1, 4'h0, i, 32'd0);
    step(0, 0, 4'h0, 0, 32'd0, 0, 4'h0, 0, 32'd0);
    check("b2b_last_data", obs_dma_rdata, 32'hA0A0_0003);

    // wait counter cleared by a one-cycle drop of dma_req_valid
    for (int k = 0; k < 5; k++) step(0, 1, 4'h0, 2, 32'd0, 1, 4'hF, 41, 32'h0BAD);
    step(0, 1, 4'h0, 2, 32'd0, 0, 4'h0, 0, 32'd0);
    grant_at = 0;
    for (int k = 1; k <= 12 && grant_at == 0; k++) begin
      step(0, 1, 4'h0, 3, 32'd0, 1, 4'hF, 41, 32'h0BAD);
      if (obs_ready) grant_at = k;
    end
    check("clear_grant_cycle", 32'(grant_at), 32'd9);

    // reset on the cycle a DMA read would be granted, then a dropped pending pulse
    step(1, 0, 4'h0, 0, 32'd0, 1, 4'h0, 16, 32'd0);
    step(0, 0, 4'h0, 0, 32'd0, 0, 4'h0, 0, 32'd0);
    check("rst_grant_no_resp", 32'(obs_resp), 32'd0);
    step(0, 0, 4'h0, 0, 32'd0, 1, 4'h0, 2, 32'd0);
    step(1, 0, 4'h0, 0, 32'd0, 0, 4'h0, 0, 32'd0);
    check("rst_drops_pending_resp", 32'(obs_resp), 32'd0);
    step(0, 0, 4'h0, 0, 32'd0, 0, 4'h0, 0, 32'd0);

    // random traffic; a DMA request is held stable until accepted
    dv = 1'b0; dwe = 4'h0; da = 0; dwd = 32'd0;
    for (int n = 0; n < 400; n++) begin
      bit          r, cr;
      logic [3:0]  cwe;
      if (!(dv && !last_g_dma)) begin
        dv  = ($urandom_range(0, 2) != 0);
        dwe = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
        da  = int'($urandom_range(0, 63));
        dwd = $urandom;
      end
      r   = ($urandom_range(0, 59) == 0);
      cr  = ($urandom_range(0, 3) != 0);
      cwe = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step(r, cr, cwe, int'($urandom_range(0, 63)), $urandom, dv, dwe, da, dwd);
      if (r) dv = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single read/write port of the data block RAM between the CPU execute stage and a secondary memory-mapped requester (DMA/bootloader copier). The CPU has fixed priority. A starvation counter forces a DMA grant after a bounded wait; on that cycle the CPU sees a one-cycle stall. The block sits between the store/write controller and the dmem port A pins, and returns read data to both requesters, accounting for the 1-cycle BRAM read latency.

Parameters:
ADDR_WIDTH, 14, word-address width of dmem port
STARVE_LIMIT, 8, cycles a pending DMA request may wait before forced grant (legal range 1..255)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cpu_req  input  1  CPU load/store access this cycle
cpu_we  input  4  CPU byte write mask (0 = read)
cpu_addr  input  ADDR_WIDTH  CPU word address
cpu_wdata  input  32  CPU write data
cpu_stall  output  1  CPU access not serviced this cycle; pipeline must hold
cpu_rdata  output  32  read data for last serviced CPU read
dma_req_valid  input  1  DMA request pending
dma_req_ready  output  1  DMA request accepted this cycle
dma_we  input  4  DMA byte write mask (0 = read)
dma_addr  input  ADDR_WIDTH  DMA word address
dma_wdata  input  32  DMA write data
dma_resp_valid  output  1  dma_rdata valid (one pulse per accepted DMA read)
dma_rdata  output  32  DMA read data
mem_addr  output  ADDR_WIDTH  to BRAM addra
mem_we  output  4  to BRAM wea
mem_din  output  32  to BRAM dina
mem_dout  input  32  from BRAM douta (valid one cycle after address)

Behaviour:
- Grant logic is combinational per cycle. grant_dma = dma_req_valid & (~cpu_req | starve_cnt == STARVE_LIMIT) & ~rst. grant_cpu = cpu_req & ~grant_dma & ~rst.
- dma_req_ready = grant_dma. cpu_stall = cpu_req & grant_dma.
- Port mux: the grant_dma cycle drives DMA addr/we/wdata. Otherwise the port is driven with CPU addr/wdata, with mem_we = cpu_we only when grant_cpu, else 0. No writes occur with no grant or during rst.
- starve_cnt (8 bit): cleared on rst, on grant_dma, or when dma_req_valid=0. Increments when dma_req_valid & ~grant_dma, and saturates at STARVE_LIMIT.
- Last-owner register last_owner (reset CPU_IDLE): set to CPU_RD, DMA_RD, or NONE each cycle from the grant and we==0.
- dma_resp_valid: registered. It is 1 in the cycle after a grant_dma with dma_we==0, else 0. dma_rdata = mem_dout while dma_resp_valid, else holds the last value.
- cpu_rdata: equals mem_dout in the cycle after a grant_cpu read. Otherwise it holds a registered copy of the last CPU read data, so a DMA access cannot corrupt a stalled CPU writeback.
- Latency: CPU read data and DMA read data both arrive 1 cycle after grant. Writes commit at the grant edge.
- Simultaneous cpu_req & dma_req_valid with starve_cnt < LIMIT: CPU wins and the counter increments.
- Simultaneous requests with starve_cnt == LIMIT: DMA wins, cpu_stall=1, and the counter clears. The next cycle the CPU wins (the counter restarts from 0).
- A DMA request held across stalls must keep addr/we/wdata stable until ready; the arbiter does not latch them.
- Reset values: cpu_stall 0, dma_req_ready 0, dma_resp_valid 0, cpu_rdata 0, dma_rdata 0, mem_we 0, starve_cnt 0.
- Reset asserted mid-operation: a pending dma_resp_valid pulse is dropped, and no response is issued for a read granted in the reset cycle.

Test Plan:
- Idle DMA read: cpu_req=0, DMA read addr 0x10 (mem holds 0xDEADBEEF) -> ready=1 same cycle, next cycle dma_resp_valid=1, dma_rdata=0xDEADBEEF, cpu_stall=0 throughout.
- CPU store contention: cpu_req=1 continuously with DMA write pending, STARVE_LIMIT=8 -> DMA granted on cycle 9, cpu_stall=1 only that cycle, mem_we=dma_we that cycle, cpu_we on the other 8 cycles.
- CPU read across forced DMA grant: CPU reads addr 5 (0x1234), next cycle forced DMA read -> cpu_rdata stays 0x1234 during the stall cycle, and dma_rdata equals the DMA data one cycle later.
- Back-to-back DMA reads with cpu_req=0, addrs 0..3 -> four consecutive resp pulses carrying mem[0..3] in order, one cycle after each ready.
- Counter clear: DMA valid for 5 cycles under CPU load, then dropped for 1 cycle, then reasserted -> forced grant only after a further 8 waiting cycles.
- Reset mid-op: rst asserted the cycle a DMA read is granted -> no dma_resp_valid, all outputs at reset values, mem_we=0 while rst=1.
